// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU issue/retire stage: default datapath
// width, ALU opcode constants, FSM state encoding and a helper that
// tells whether an opcode produces a meaningful carry/borrow.
// No ports (package).

package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_NAND  = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_NOR   = 4'b0110;
    localparam logic [3:0] OP_NOT   = 4'b0111;
    localparam logic [3:0] OP_ADD1  = 4'b1000;
    localparam logic [3:0] OP_SUB1  = 4'b1001;
    localparam logic [3:0] OP_AND1  = 4'b1010;
    localparam logic [3:0] OP_OR1   = 4'b1011;
    localparam logic [3:0] OP_NAND1 = 4'b1100;
    localparam logic [3:0] OP_XOR1  = 4'b1101;
    localparam logic [3:0] OP_NOR1  = 4'b1110;
    localparam logic [3:0] OP_NOT1  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Only the add/subtract family (x00x) drives a real carry out of the ALU;
    // for every other opcode the ALU carry line is meaningless.
    function automatic logic op_has_carry(input logic [3:0] op);
        return (op[2:1] == 2'b00);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
// Command and result handshake channels of the ALU issue stage.
//   cmd_*  : command channel (valid/ready), operands, opcode, accumulator select
//   res_*  : result channel (valid/ready), captured result and flags
// Modports: master = command producer / result consumer, slave = issue stage.

interface alu_issue_ctrl_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero
    );

endinterface

// File: rtl/alu_issue_fsm.sv
// alu_issue_fsm
// Control FSM of the ALU issue stage: state register, settle counter and
// handshake outputs. One operation is in flight at a time.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   cmd_valid   : command offered          res_ready : consumer takes result
//   cmd_ready   : ready for a command      res_valid : result available
//   accept      : command accepted at this edge (load operands)
//   capture     : ALU output sampled at this edge
//   busy        : in EXEC (accumulator clear is ignored there)

module alu_issue_fsm
    import alu_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic res_ready,
    output logic cmd_ready,
    output logic res_valid,
    output logic accept,
    output logic capture,
    output logic busy
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          res_valid_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            res_valid <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            res_valid <= res_valid_next;
        end
    end

    // The counter is loaded with SETTLE-1 on accept, so the capture edge is
    // exactly SETTLE edges after the accepting edge.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        res_valid_next = res_valid;
        cmd_ready      = 1'b0;
        accept         = 1'b0;
        capture        = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                busy = 1'b1;
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    capture        = 1'b1;
                    res_valid_next = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Issue/retire stage around an external 8-bit combinational ALU. Accepts a
// command, holds registered operands on the ALU for SETTLE cycles, captures
// the result with carry/zero flags, keeps an accumulator for chaining and
// counts retired operations (saturating).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : command / result handshake channels
//   acc_clr             : synchronous accumulator clear
//   alu_x/alu_y/alu_cntrl : registered operands and opcode to the ALU
//   alu_out/alu_carry   : ALU result and carry/borrow
//   acc                 : accumulator value
//   op_count            : retired operations, saturating

module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int SETTLE = 1,
    parameter int CNTW   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_issue_ctrl_if.slave     bus,
    input  logic                acc_clr,
    output logic [WIDTH-1:0]    alu_x,
    output logic [WIDTH-1:0]    alu_y,
    output logic [3:0]          alu_cntrl,
    input  logic [WIDTH-1:0]    alu_out,
    input  logic                alu_carry,
    output logic [WIDTH-1:0]    acc,
    output logic [CNTW-1:0]     op_count
);

    logic             cmd_ready;
    logic             res_valid;
    logic             accept;
    logic             capture;
    logic             busy;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;

    alu_issue_fsm #(
        .SETTLE (SETTLE)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (bus.cmd_valid),
        .res_ready (bus.res_ready),
        .cmd_ready (cmd_ready),
        .res_valid (res_valid),
        .accept    (accept),
        .capture   (capture),
        .busy      (busy)
    );

    assign bus.cmd_ready = cmd_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_carry = res_carry;
    assign bus.res_zero  = res_zero;

    // Operands are sampled only on the accepting edge; the accumulator read
    // here is the pre-clear value even if acc_clr is high in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_x     <= '0;
            alu_y     <= '0;
            alu_cntrl <= '0;
        end else if (accept) begin
            alu_x     <= bus.cmd_use_acc ? acc : bus.cmd_a;
            alu_y     <= bus.cmd_b;
            alu_cntrl <= bus.cmd_op;
        end
    end

    // Result registers hold their value after retire until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
        end else if (capture) begin
            res_data  <= alu_out;
            res_carry <= op_has_carry(alu_cntrl) ? alu_carry : 1'b0;
            res_zero  <= (alu_out == '0);
        end
    end

    // A capture write wins over acc_clr; clear is ignored throughout EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (capture) begin
            acc <= alu_out;
        end else if (acc_clr && !busy) begin
            acc <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (capture && (op_count != '1)) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Self-checking bench for alu_issue_ctrl. dut1 (SETTLE=1) runs a table of
// commands through a scoreboard queue plus backpressure, accumulator-clear
// and mid-operation reset sequences. dut2 (SETTLE=3, CNTW=2) checks operand
// hold time, capture timing and counter saturation. A behavioural ALU stub
// feeds both instances; its carry line is 1 for logic ops so that carry
// masking is visible.

module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk;
    logic rst_n;

    alu_issue_ctrl_if #(.WIDTH(8)) bus1 ();
    alu_issue_ctrl_if #(.WIDTH(8)) bus2 ();

    logic       acc_clr1, acc_clr2;
    logic [7:0] alu_x1, alu_y1, alu_out1, acc1;
    logic [7:0] alu_x2, alu_y2, alu_out2, acc2;
    logic [3:0] alu_cntrl1, alu_cntrl2;
    logic       alu_carry1, alu_carry2;
    logic [15:0] op_count1;
    logic [1:0]  op_count2;

    int n_checks = 0;
    int n_fail   = 0;
    int model_count = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
        logic       clr;
        logic [7:0] exp_data;
        logic       exp_carry;
        logic       exp_zero;
        logic [7:0] exp_acc;
    } vec_t;

    typedef struct {
        logic [7:0]  data;
        logic        carry;
        logic        zero;
        logic [7:0]  acc;
        logic [15:0] count;
    } sb_t;

    vec_t tbl [13];
    sb_t  sb_q [$];

    alu_issue_ctrl #(.WIDTH(8), .SETTLE(1), .CNTW(16)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .acc_clr   (acc_clr1),
        .alu_x     (alu_x1),
        .alu_y     (alu_y1),
        .alu_cntrl (alu_cntrl1),
        .alu_out   (alu_out1),
        .alu_carry (alu_carry1),
        .acc       (acc1),
        .op_count  (op_count1)
    );

    alu_issue_ctrl #(.WIDTH(8), .SETTLE(3), .CNTW(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus2),
        .acc_clr   (acc_clr2),
        .alu_x     (alu_x2),
        .alu_y     (alu_y2),
        .alu_cntrl (alu_cntrl2),
        .alu_out   (alu_out2),
        .alu_carry (alu_carry2),
        .acc       (acc2),
        .op_count  (op_count2)
    );

    // Behavioural stand-in for the external ALU; opcode bit 3 is ignored.
    function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [8:0] r;
        case (op[2:0])
            3'd0:    r = {1'b0, x} + {1'b0, y};
            3'd1:    r = {(x < y), 8'(x - y)};
            3'd2:    r = {1'b1, x & y};
            3'd3:    r = {1'b1, x | y};
            3'd4:    r = {1'b1, ~(x & y)};
            3'd5:    r = {1'b1, x ^ y};
            3'd6:    r = {1'b1, ~(x | y)};
            default: r = {1'b1, ~x};
        endcase
        return r;
    endfunction

    always_comb {alu_carry1, alu_out1} = alu_model(alu_cntrl1, alu_x1, alu_y1);
    always_comb {alu_carry2, alu_out2} = alu_model(alu_cntrl2, alu_x2, alu_y2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case some sequence never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual running, required finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic noteFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: actual timeout, required event within bound", name);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge,
    // having pushed the expected result for this command.
    task automatic applyStimulus(input vec_t v);
        int guard;
        sb_t e;
        guard = 0;
        bus1.cmd_op      = v.op;
        bus1.cmd_a       = v.a;
        bus1.cmd_b       = v.b;
        bus1.cmd_use_acc = v.use_acc;
        bus1.cmd_valid   = 1'b1;
        while (!bus1.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus1.cmd_ready) begin
            noteFail("cmd_accept");
            bus1.cmd_valid = 1'b0;
            return;
        end
        acc_clr1 = v.clr;
        @(posedge clk);
        model_count++;
        e.data  = v.exp_data;
        e.carry = v.exp_carry;
        e.zero  = v.exp_zero;
        e.acc   = v.exp_acc;
        e.count = 16'(model_count);
        sb_q.push_back(e);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        acc_clr1       = 1'b0;
    endtask

    task automatic checkOutput(input int exp_lat);
        int lat;
        sb_t e;
        lat = 0;
        while (!bus1.res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!bus1.res_valid) begin
            noteFail("res_valid_wait");
            return;
        end
        compare("latency", lat, exp_lat);
        if (sb_q.size() == 0) begin
            noteFail("scoreboard_empty");
            return;
        end
        e = sb_q.pop_front();
        compare("res_data",  bus1.res_data,  e.data);
        compare("res_carry", bus1.res_carry, e.carry);
        compare("res_zero",  bus1.res_zero,  e.zero);
        compare("acc",       acc1,           e.acc);
        compare("op_count",  op_count1,      e.count);
    endtask

    // dut2 single operation: checks operand hold for 3 cycles, capture at N+3.
    task automatic run2(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input logic [7:0] exp_x, input logic [7:0] exp_data,
                        input logic exp_carry, input logic exp_zero, input logic [1:0] exp_count);
        int guard;
        guard = 0;
        bus2.cmd_op = op; bus2.cmd_a = a; bus2.cmd_b = b; bus2.cmd_use_acc = ua;
        bus2.cmd_valid = 1'b1;
        while (!bus2.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus2.cmd_ready) begin
            noteFail("dut2_accept");
            bus2.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus2.cmd_valid = 1'b0;
        bus2.cmd_op = ~op; bus2.cmd_a = ~a; bus2.cmd_b = ~b;
        for (int k = 0; k < 3; k++) begin
            compare("dut2_res_valid_early", bus2.res_valid, 1'b0);
            compare("dut2_alu_x_hold", alu_x2, exp_x);
            compare("dut2_alu_y_hold", alu_y2, b);
            compare("dut2_alu_cntrl_hold", alu_cntrl2, op);
            @(negedge clk);
        end
        compare("dut2_res_valid", bus2.res_valid, 1'b1);
        compare("dut2_res_data", bus2.res_data, exp_data);
        compare("dut2_res_carry", bus2.res_carry, exp_carry);
        compare("dut2_res_zero", bus2.res_zero, exp_zero);
        compare("dut2_acc", acc2, exp_data);
        compare("dut2_op_count", op_count2, exp_count);
    endtask

    initial begin
        vec_t v;
        int guard;
        sb_t e;

        //             op     a      b      ua    clr   data   c     z     acc
        tbl[0]  = '{4'h0, 8'h4F, 8'hA5, 1'b0, 1'b0, 8'hF4, 1'b0, 1'b0, 8'hF4};
        tbl[1]  = '{4'h0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[2]  = '{4'h2, 8'h4F, 8'hA5, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 8'h05};
        tbl[3]  = '{4'h0, 8'h10, 8'h05, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0, 8'h15};
        tbl[4]  = '{4'h0, 8'hEE, 8'h03, 1'b1, 1'b0, 8'h18, 1'b0, 1'b0, 8'h18};
        tbl[5]  = '{4'h1, 8'h20, 8'h30, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, 8'hF0};
        tbl[6]  = '{4'h5, 8'h5A, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5};
        tbl[7]  = '{4'h8, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[8]  = '{4'h7, 8'h55, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF};
        tbl[9]  = '{4'hB, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF};
        tbl[10] = '{4'h0, 8'h00, 8'h01, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[11] = '{4'h1, 8'h05, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[12] = '{4'h4, 8'h0F, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 8'hF0};

        rst_n = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_op = '0; bus1.cmd_a = '0; bus1.cmd_b = '0;
        bus1.cmd_use_acc = 1'b0; bus1.res_ready = 1'b1; acc_clr1 = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.cmd_op = '0; bus2.cmd_a = '0; bus2.cmd_b = '0;
        bus2.cmd_use_acc = 1'b0; bus2.res_ready = 1'b1; acc_clr2 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        compare("rst_res_valid", bus1.res_valid, 1'b0);
        compare("rst_res_data", bus1.res_data, 8'h00);
        compare("rst_res_carry", bus1.res_carry, 1'b0);
        compare("rst_res_zero", bus1.res_zero, 1'b0);
        compare("rst_acc", acc1, 8'h00);
        compare("rst_alu_x", alu_x1, 8'h00);
        compare("rst_alu_y", alu_y1, 8'h00);
        compare("rst_alu_cntrl", alu_cntrl1, 4'h0);
        compare("rst_op_count", op_count1, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        compare("rst_cmd_ready", bus1.cmd_ready, 1'b1);
        compare("rst_cmd_ready2", bus2.cmd_ready, 1'b1);

        // Table-driven command sequence through the scoreboard
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i]);
            checkOutput(1);
        end

        // acc_clr in IDLE; result registers keep their value after retire
        @(negedge clk);
        acc_clr1 = 1'b1;
        @(negedge clk);
        acc_clr1 = 1'b0;
        compare("acc_clr_idle", acc1, 8'h00);
        compare("res_hold_after_retire", bus1.res_data, 8'hF0);
        compare("res_valid_after_retire", bus1.res_valid, 1'b0);

        // Backpressure with a competing command and acc_clr during RESP
        bus1.res_ready = 1'b0;
        v = '{4'h0, 8'h21, 8'h11, 1'b0, 1'b0, 8'h32, 1'b0, 1'b0, 8'h32};
        applyStimulus(v);
        checkOutput(1);
        bus1.cmd_op = 4'h0; bus1.cmd_a = 8'h77; bus1.cmd_b = 8'h01;
        bus1.cmd_use_acc = 1'b0; bus1.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compare("bp_res_valid", bus1.res_valid, 1'b1);
            compare("bp_res_data", bus1.res_data, 8'h32);
            compare("bp_cmd_ready", bus1.cmd_ready, 1'b0);
            compare("bp_alu_x", alu_x1, 8'h21);
            if (i == 2) compare("acc_clr_resp", acc1, 8'h00);
            acc_clr1 = (i == 0);
        end
        bus1.res_ready = 1'b1;
        @(negedge clk);
        compare("retire_res_valid", bus1.res_valid, 1'b0);
        compare("retire_cmd_ready", bus1.cmd_ready, 1'b1);
        compare("retire_res_data", bus1.res_data, 8'h32);
        compare("retire_alu_x", alu_x1, 8'h21);
        @(posedge clk);
        model_count++;
        e.data = 8'h78; e.carry = 1'b0; e.zero = 1'b0; e.acc = 8'h78; e.count = 16'(model_count);
        sb_q.push_back(e);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        compare("second_cmd_alu_x", alu_x1, 8'h77);
        checkOutput(1);

        // SETTLE=3 instance: hold time, capture timing, counter saturation
        @(negedge clk);
        run2(4'h1, 8'h10, 8'h20, 1'b0, 8'h10, 8'hF0, 1'b1, 1'b0, 2'd1);
        run2(4'h5, 8'h00, 8'h0F, 1'b1, 8'hF0, 8'hFF, 1'b0, 1'b0, 2'd2);
        run2(4'h0, 8'h01, 8'h01, 1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 2'd3);
        run2(4'h3, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'd3);

        // Reset asserted during EXEC discards the in-flight operation
        @(negedge clk);
        bus1.cmd_op = 4'h0; bus1.cmd_a = 8'h01; bus1.cmd_b = 8'h02;
        bus1.cmd_use_acc = 1'b0; bus1.cmd_valid = 1'b1;
        guard = 0;
        while (!bus1.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus1.cmd_ready) noteFail("rst_test_accept");
        @(posedge clk);
        #1;
        bus1.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        compare("midrst_res_valid", bus1.res_valid, 1'b0);
        compare("midrst_acc", acc1, 8'h00);
        compare("midrst_op_count", op_count1, 16'h0);
        compare("midrst_alu_x", alu_x1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        compare("postrst_res_valid", bus1.res_valid, 1'b0);
        compare("postrst_cmd_ready", bus1.cmd_ready, 1'b1);
        compare("postrst_op_count", op_count1, 16'h0);
        compare("postrst_res_data", bus1.res_data, 8'h00);
        model_count = 0;
        v = '{4'h0, 8'h40, 8'h02, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0, 8'h42};
        applyStimulus(v);
        checkOutput(1);
        if (sb_q.size() != 0) noteFail("scoreboard_leftover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential issue/retire stage that wraps the 8-bit combinational ALU (x, y, 4-bit cntrl -> out, carry).
- Accepts one command at a time over a valid/ready handshake and drives registered operands and opcode into the ALU.
- Waits a programmable settle time, captures out/carry, and presents the result with flags over a second valid/ready handshake.
- Keeps an accumulator so that operations can be chained.

Parameters:
WIDTH, 8, datapath width; must match the ALU operand width.
SETTLE, 1, cycles the ALU inputs are held stable before sampling; must be >= 1.
CNTW, 16, width of the retired-operation counter.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  4  ALU opcode, passed to cntrl unchanged
cmd_a  in  WIDTH  operand x (ignored when cmd_use_acc=1)
cmd_b  in  WIDTH  operand y
cmd_use_acc  in  1  use the accumulator as x
acc_clr  in  1  synchronous accumulator clear
alu_x  out  WIDTH  registered x to ALU
alu_y  out  WIDTH  registered y to ALU
alu_cntrl  out  4  registered opcode to ALU
alu_out  in  WIDTH  ALU result
alu_carry  in  1  ALU carry/borrow
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_data  out  WIDTH  captured result
res_carry  out  1  carry flag
res_zero  out  1  result == 0
acc  out  WIDTH  accumulator value
op_count  out  CNTW  retired operations, saturating

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_ready=1 after release; res_valid=0; res_data=0; res_carry=0; res_zero=0; acc=0; alu_x=alu_y=0; alu_cntrl=0; op_count=0; settle counter=0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at an edge: alu_x<=(cmd_use_acc ? acc : cmd_a); alu_y<=cmd_b; alu_cntrl<=cmd_op; cnt<=SETTLE-1; go to EXEC.
- EXEC:
  - cmd_ready=0; ALU inputs stay constant.
  - If cnt!=0, decrement cnt.
  - At the edge with cnt==0:
    - res_data<=alu_out.
    - res_carry<=alu_carry when cntrl[2:1]==2'b00 (add/sub ops 0000, 0001, 1000, 1001), else 0.
    - res_zero<=(alu_out==0).
    - acc<=alu_out.
    - op_count<=op_count+1, saturating at all-ones.
    - res_valid<=1; go to RESP.
- RESP:
  - res_valid=1; outputs stable while res_ready=0.
  - On res_ready=1 at an edge: res_valid<=0; go to IDLE.
  - res_data and flags hold their last values after retire.
  - cmd_ready=0 in RESP: no command overlap, one op in flight.
- Latency with SETTLE=1: command accepted at edge N; result captured at edge N+1; res_valid high from N+1.
  - Minimum throughput is one op per 3 cycles when res_ready is held at 1.
- acc_clr:
  - Clears acc at the next edge in IDLE or RESP.
  - In EXEC, the capture write wins over acc_clr.
  - An IDLE accept with cmd_use_acc=1 and acc_clr=1 in the same cycle uses the pre-clear acc value.
- Command fields are sampled only at the accepting edge; changes while cmd_ready=0 are ignored.
- Reset asserted mid-EXEC or mid-RESP: immediate return to IDLE with all reset values; the in-flight op is discarded and not counted.
- Arithmetic: no width extension; carry comes from the ALU only. The block computes nothing except the zero flag and the counter increment.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH default.
  - Opcode constants: OP_ADD=4'b0000, OP_SUB=4'b0001, OP_AND=4'b0010, OP_OR=4'b0011, OP_NAND=4'b0100, OP_XOR=4'b0101, OP_NOR=4'b0110, OP_NOT=4'b0111, and the 1xxx variants.
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
  - Helper function op_has_carry(op) = (op[2:1]==2'b00).
- One natural sub-module: alu_issue_fsm (state register, settle counter, handshake outputs). The datapath registers stay in the top.
- The ALU is instantiated outside this block.

Test Plan:
1. Reset then accept cmd_op=0000, a=0x4F, b=0xA5, SETTLE=1, res_ready=1 -> res_valid one cycle after accept; res_data=0xF4, carry=0, zero=0, acc=0xF4, op_count=1.
2. cmd_op=0000, a=0xFF, b=0x01 -> res_data=0x00, carry=1, zero=1; then cmd_op=0010 (AND) with a=0x4F, b=0xA5 -> res_data=0x05, carry forced 0.
3. Chain: a=0x10 ADD b=0x05 (acc=0x15), then use_acc=1 ADD b=0x03 -> res_data=0x18; then acc_clr in IDLE -> acc=0x00.
4. Backpressure: res_ready=0 for 5 cycles after result -> res_valid stays 1, data stable, cmd_ready=0, and a second cmd_valid is not accepted until 1 cycle after res_ready pulse.
5. SETTLE=3: alu_x/y/cntrl stable for 3 cycles after accept; capture at edge N+3; result matches the behavioural ALU model.
6. rst_n pulsed low during EXEC -> res_valid=0, acc=0, op_count unchanged from reset value 0, cmd_ready=1 after release; the next command completes normally.
